// File: rtl/aes_pkg.sv
// Shared AES-128 constants, state typedef, FSM encoding and byte-level helpers.
package aes_pkg;

    localparam int NR = 10;
    localparam logic [7:0] RCON_START = 8'h01;
    localparam logic [7:0] RCON_POLY  = 8'h1b;

    // Byte 0 is the most significant byte; byte index = 4*column + row.
    typedef logic [0:15][7:0] aes_state_t;

    typedef enum logic [1:0] {StIdle, StRun, StDone} eng_state_e;

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return SBOX_TABLE[idx +: 8];
    endfunction

    // Multiply by x in GF(2^8).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] byte_at(input aes_state_t s, input int row, input int col);
        return s[4'(4 * col + row)];
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic aes_state_t sub_byte(input aes_state_t s);
        aes_state_t o;
        for (int i = 0; i < 16; i++) begin
            o[4'(i)] = sbox(s[4'(i)]);
        end
        return o;
    endfunction

    // Row r rotates left by r positions.
    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[4'(4 * c + r)] = byte_at(s, r, (c + r) % 4);
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES-128 round together with the matching key-schedule step.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic [7:0]   rcon,
    input  logic         last,
    output logic [127:0] next_state,
    output logic [127:0] next_key,
    output logic [7:0]   next_rcon
);

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    aes_state_t   shifted;
    logic [127:0] shifted_flat;
    logic [127:0] mixed;
    logic [31:0]  w0, w1, w2, w3, temp, k0, k1, k2, k3;

    // SubBytes followed by ShiftRows on the whole state.
    always_comb begin
        shifted = shift_rows(sub_byte(aes_state_t'(state)));
    end

    assign shifted_flat = shifted;

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mixed[127 - 32 * c -: 32] = mix_column(shifted_flat[127 - 32 * c -: 32]);
    end

    assign {w0, w1, w2, w3} = round_key;
    assign temp = sub_word(rot_word(w3)) ^ {rcon, 24'h000000};
    assign k0   = w0 ^ temp;
    assign k1   = w1 ^ k0;
    assign k2   = w2 ^ k1;
    assign k3   = w3 ^ k2;

    assign next_key   = {k0, k1, k2, k3};
    assign next_state = (last ? shifted_flat : mixed) ^ next_key;
    assign next_rcon  = xtime(rcon);

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryptor applying UNROLL rounds per clock with an on-the-fly key schedule.
module aes_round_engine
    import aes_pkg::*;
#(
    parameter int unsigned UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
        $fatal(1, "aes_round_engine: UNROLL must be 1, 2, 5 or 10");
    end

    eng_state_e   state_q, state_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] key_q, key_d;
    logic [127:0] dout_q, dout_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         run_done;

    logic [127:0] st_chain  [UNROLL + 1];
    logic [127:0] key_chain [UNROLL + 1];
    logic [7:0]   rc_chain  [UNROLL + 1];

    assign st_chain[0]  = blk_q;
    assign key_chain[0] = key_q;
    assign rc_chain[0]  = rcon_q;

    // Stage i applies round cnt_q + i; the final round is detected per stage.
    for (genvar i = 0; i < UNROLL; i++) begin : g_stage
        aes_round u_round (
            .state      (st_chain[i]),
            .round_key  (key_chain[i]),
            .rcon       (rc_chain[i]),
            .last       ((int'(cnt_q) + i) == NR),
            .next_state (st_chain[i + 1]),
            .next_key   (key_chain[i + 1]),
            .next_rcon  (rc_chain[i + 1])
        );
    end

    assign run_done = (int'(cnt_q) + int'(UNROLL) - 1) == NR;

    // Next-state logic: accept in IDLE, iterate in RUN, hold result in DONE.
    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        key_d   = key_q;
        dout_d  = dout_q;
        rcon_d  = rcon_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    blk_d   = data_in ^ key_in;
                    key_d   = key_in;
                    cnt_d   = 4'd1;
                    rcon_d  = RCON_START;
                    state_d = StRun;
                end
            end
            StRun: begin
                blk_d  = st_chain[UNROLL];
                key_d  = key_chain[UNROLL];
                rcon_d = rc_chain[UNROLL];
                cnt_d  = cnt_q + 4'(UNROLL);
                if (run_done) begin
                    dout_d  = st_chain[UNROLL];
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            blk_q   <= '0;
            key_q   <= '0;
            dout_q  <= '0;
            rcon_q  <= RCON_START;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            key_q   <= key_d;
            dout_q  <= dout_d;
            rcon_q  <= rcon_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StRun);
    assign data_out  = dout_q;

endmodule

// File: tb/tb_aes_round_engine.sv
// Self-checking bench: four engines (UNROLL 1, 2, 5, 10) against a behavioural AES-128 model.
module tb_aes_round_engine;

    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [3:0]   in_valid, out_ready, in_ready, out_valid, busy;
    logic [127:0] data_in, key_in;
    logic [127:0] data_out [4];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        aes_round_engine #(
            .UNROLL (g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 5 : 10)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .data_in   (data_in),
            .key_in    (key_in),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .data_out  (data_out[g]),
            .busy      (busy[g])
        );
    end

    // ---------------- reference model ----------------
    logic [7:0] sbox_m [256];

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // S-box from the multiplicative inverse and the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [31:0]  tw;
        logic [7:0]   rc;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tw = w[i - 1];
            if (i % 4 == 0) begin
                tw = {tw[23:0], tw[31:24]};
                tw = {sbox_m[tw[31:24]], sbox_m[tw[23:16]], sbox_m[tw[15:8]], sbox_m[tw[7:0]]}
                     ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ tw;
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = pt[127 - 8 * (4 * c + r) -: 8] ^ w[c][31 - 8 * r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sbox_m[s[r][(c + r) % 4]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    if (rnd < 10)
                        s[r][c] = gf_mul(8'h02, t[r][c]) ^ gf_mul(8'h03, t[(r + 1) % 4][c]) ^
                                  t[(r + 2) % 4][c] ^ t[(r + 3) % 4][c];
                    else
                        s[r][c] = t[r][c];
                    s[r][c] = s[r][c] ^ w[4 * rnd + c][31 - 8 * r -: 8];
                end
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                res[127 - 8 * (4 * c + r) -: 8] = s[r][c];
        return res;
    endfunction

    // ---------------- helpers ----------------
    function automatic int unr(input logic [1:0] u);
        case (u)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 5;
            default: return 10;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One block through engine u: accept, latency, result, optional backpressure, handshake.
    task automatic run_block(input logic [1:0] u, input logic [127:0] key, input logic [127:0] pt,
                             input logic [127:0] exp, input int hold, input string tag);
        int n;
        n = 0;
        while (!in_ready[u] && n < 40) begin tick(); n++; end
        checkb({tag, " in_ready"}, in_ready[u], 1'b1);
        data_in = pt;
        key_in = key;
        in_valid[u] = 1'b1;
        tick();
        in_valid[u] = 1'b0;
        checkb({tag, " busy"}, busy[u], 1'b1);
        n = 0;
        while (!out_valid[u] && n < 40) begin tick(); n++; end
        checki({tag, " latency"}, n, 10 / unr(u));
        check128({tag, " data"}, data_out[u], exp);
        if (hold > 0) begin
            repeat (hold) tick();
            checkb({tag, " held valid"}, out_valid[u], 1'b1);
            check128({tag, " held data"}, data_out[u], exp);
        end
        out_ready[u] = 1'b1;
        tick();
        out_ready[u] = 1'b0;
        checkb({tag, " valid drop"}, out_valid[u], 1'b0);
        checkb({tag, " idle ready"}, in_ready[u], 1'b1);
    endtask

    // Hold in_valid/out_ready high and run B then C.1 back to back.
    task automatic back_to_back(input logic [1:0] u);
        int acc, nout;
        int acc_t [2];
        logic [127:0] outs [2];
        logic acc_now;
        acc = 0;
        nout = 0;
        acc_t[0] = 0;
        acc_t[1] = 0;
        outs[0] = '0;
        outs[1] = '0;
        data_in = B_PT;
        key_in = B_KEY;
        in_valid[u] = 1'b1;
        out_ready[u] = 1'b1;
        for (int n = 0; n < 80 && nout < 2; n++) begin
            acc_now = in_ready[u] && in_valid[u];
            if (out_valid[u]) begin
                outs[nout] = data_out[u];
                nout++;
            end
            tick();
            if (acc_now && acc < 2) begin
                acc_t[acc] = n;
                acc++;
                if (acc == 1) begin
                    data_in = C1_PT;
                    key_in = C1_KEY;
                end else begin
                    in_valid[u] = 1'b0;
                end
            end
        end
        in_valid[u] = 1'b0;
        out_ready[u] = 1'b0;
        checki("b2b accepts", acc, 2);
        checki("b2b outputs", nout, 2);
        check128("b2b first", outs[0], B_CT);
        check128("b2b second", outs[1], C1_CT);
        checki("b2b spacing", acc_t[1] - acc_t[0], 10 / unr(u) + 2);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [127:0] rk, rp;
        int n;
        rst = 1'b1;
        in_valid = '0;
        out_ready = '0;
        data_in = '0;
        key_in = '0;
        build_sbox();

        // Reset state
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            checkb("rst in_ready", in_ready[k], 1'b0);
            checkb("rst out_valid", out_valid[k], 1'b0);
            checkb("rst busy", busy[k], 1'b0);
            check128("rst data_out", data_out[k], '0);
        end
        rst = 1'b0;
        #1;
        checkb("post-rst in_ready", in_ready[0], 1'b1);

        // FIPS-197 appendix B on UNROLL=1
        run_block(2'd0, B_KEY, B_PT, B_CT, 0, "fips_b");

        // FIPS-197 C.1 on every unroll factor
        for (int k = 0; k < 4; k++) run_block(2'(k), C1_KEY, C1_PT, C1_CT, 0, "fips_c1");

        // All-zero key and plaintext
        run_block(2'd0, '0, '0, Z_CT, 0, "zero_u1");
        run_block(2'd3, '0, '0, Z_CT, 0, "zero_u10");

        // Backpressure with in_valid pulses that must be ignored
        data_in = B_PT;
        key_in = B_KEY;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        n = 0;
        while (!out_valid[0] && n < 40) begin tick(); n++; end
        for (int k = 0; k < 7; k++) begin
            in_valid[0] = k[0];
            data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            checkb("bp out_valid", out_valid[0], 1'b1);
            check128("bp data_out", data_out[0], B_CT);
            checkb("bp in_ready", in_ready[0], 1'b0);
            tick();
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        checkb("bp release valid", out_valid[0], 1'b0);
        checkb("bp release ready", in_ready[0], 1'b1);
        check128("bp retained data", data_out[0], B_CT);
        tick();
        checkb("bp no phantom busy", busy[0], 1'b0);

        // Reset pulsed while round 4 is pending
        data_in = B_PT;
        key_in = B_KEY;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkb("abort out_valid", out_valid[0], 1'b0);
        check128("abort data_out", data_out[0], '0);
        checkb("abort in_ready", in_ready[0], 1'b1);
        checkb("abort busy", busy[0], 1'b0);
        repeat (12) tick();
        checkb("abort no output", out_valid[0], 1'b0);
        run_block(2'd0, C1_KEY, C1_PT, C1_CT, 0, "after_abort");

        // Back-to-back blocks
        back_to_back(2'd0);
        back_to_back(2'd3);

        // Random blocks against the model, random consumer delay
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) begin
                rk = {$urandom(), $urandom(), $urandom(), $urandom()};
                rp = {$urandom(), $urandom(), $urandom(), $urandom()};
                run_block(2'(k), rk, rp, aes_ref(rk, rp), int'($urandom_range(0, 3)), "random");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
